switch_sequencer: RTL and testbench
===================================

# switch_sequencer

Downstream consumer of the 2.083 kHz switch clock. Each rising edge of that clock advances a one-hot analog-switch channel select on the PMOD outputs. The select is driven break-before-make: all selects go low for a fixed dead time, then the next channel closes. After a settle interval the block emits a one-cycle ADC sample strobe, so every switch period yields exactly one settled sample per channel.

## Interface
- `NUM_CH`, default 4: number of switch channels, legal range 2..16.
- `DEAD_CYCLES`, default 100: break-before-make gap in `clk` cycles (1 µs at 100 MHz); minimum 1.
- `SETTLE_CYCLES`, default 2000: wait in `clk` cycles from channel close to sample strobe (20 µs); minimum 1.
- `clk`  in  1: 100 MHz system clock; the only clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `switch_clk`  in  1: level output of the switch clock divider.
- `enable`  in  1: run control; low forces idle.
- `sel`  out  `NUM_CH`: one-hot switch select; all-zero during dead time and idle.
- `ch_idx`  out  `$clog2(NUM_CH)`: index of the closed channel.
- `sample_stb`  out  1: one-cycle ADC sample request.
- `frame_start`  out  1: one-cycle pulse when channel 0 closes.
- `overrun`  out  1: sticky error flag.

## Operation
- Reset values: `sel`=0, `ch_idx`=0, `sample_stb`=0, `frame_start`=0, `overrun`=0, state IDLE, next-channel pointer=0.
- Edge detect: a rising edge is `switch_clk`=1 with previous registered sample 0. "Edge cycle E" is the `clk` edge at which the FSM first sees the rise.
- FSM states:
  - IDLE, then BREAK on an edge when `enable`=1.
  - BREAK: `sel`=0 for `DEAD_CYCLES` cycles, then MAKE.
  - MAKE, folded into the BREAK exit: loads `sel`/`ch_idx` with the next channel and advances the pointer, wrapping `NUM_CH-1` to 0.
  - SETTLE: lasts `SETTLE_CYCLES` cycles, then HOLD.
  - HOLD: goes to BREAK on an edge.
- First edge after reset or after enable lands on channel 0.
- `sample_stb` is high in the first HOLD cycle only.
- `frame_start` is high for exactly the cycle on which `ch_idx` first shows 0 with `sel[0]`=1.
- Boundary conditions:
  - Edge during BREAK or SETTLE: ignored, `overrun` set to 1. Sequence continues unchanged.
  - Edge in the first HOLD cycle, coincident with the strobe: accepted. `sample_stb` still pulses, and BREAK starts the next cycle.
  - `enable` falls in any state: next cycle is IDLE, `sel`=0, pointer=0. No `sample_stb` for an aborted slot.
  - `enable` low clears `overrun`. Otherwise only `rst` clears it.
  - `rst` mid-operation: all outputs return to reset values immediately (asynchronous).
  - Counters are sized `$clog2(max(DEAD_CYCLES,SETTLE_CYCLES)+1)` bits. No wrap within a phase.
- Integration requirement: `DEAD_CYCLES + SETTLE_CYCLES + 4` must be less than the switch period (48000).

## Timing
- Edge cycle E:
  - `sel`=0 and `sample_stb`=0 from E+1 through E+`DEAD_CYCLES`.
  - `sel[ch]`, `ch_idx` and `frame_start` (if ch=0) are valid from E+`DEAD_CYCLES`+1.
  - `sample_stb` is high at E+`DEAD_CYCLES`+`SETTLE_CYCLES`+1.
- All outputs are registered, with no combinational path from inputs.
- `sel` is never multi-hot in any cycle.
- Sync latency from a `switch_clk` rise to E is set by `SWITCH_SEQ_SYNC_EN`, below.

## Configuration
- `SWITCH_SEQ_SYNC_EN` defined:
  - `switch_clk` passes through a 2-flop synchronizer before edge detection.
  - E is the 3rd `clk` edge after the input rises.
  - Required when the divider output is looped back through the PMOD pins.
- Not defined:
  - `switch_clk` is treated as synchronous to `clk`, with a single previous-value register.
  - E is the 1st `clk` edge at which `switch_clk`=1 is sampled.
  - All other behaviour is identical.

## Test plan
- Reset, `enable`=1, one rising edge at E, defaults → `sel`=0 during E+1..E+100, then `sel`=4'b0001, `ch_idx`=0 and `frame_start`=1 at E+101, then `sample_stb`=1 for one cycle at E+2101.
- Five edges, 48000 cycles apart → `ch_idx` sequence 0,1,2,3,0. `frame_start` fires on the 1st and 5th. `sel` is never multi-hot.
- Second edge at E+1000 (in SETTLE) → `overrun`=1, no extra channel advance, `sample_stb` still at E+2101.
- `enable` dropped at E+500 → `sel`=0 and no strobe from E+501. Re-enable plus an edge → channel 0 and `frame_start`=1.
- `rst` pulsed at E+1500 for 3 cycles → all outputs 0 asynchronously. The next edge yields channel 0.
- With and without `SWITCH_SEQ_SYNC_EN`, an asynchronous `switch_clk` rise → `sel` drops at input+4 and input+2 cycles respectively.

Source files
------------

// File: rtl/switch_sequencer.sv
// switch_sequencer: break-before-make one-hot analog switch sequencer.
// Each rising edge of switch_clk opens every switch for DEAD_CYCLES cycles,
// then closes the next channel. After SETTLE_CYCLES it raises one ADC sample strobe.
// Optional macro SWITCH_SEQ_SYNC_EN adds a 2-flop synchronizer on switch_clk.
// Use it when switch_clk is not synchronous to clk.
module switch_sequencer #(
    parameter int NUM_CH        = 4,
    parameter int DEAD_CYCLES   = 100,
    parameter int SETTLE_CYCLES = 2000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      switch_clk,
    input  logic                      enable,
    output logic [NUM_CH-1:0]         sel,
    output logic [$clog2(NUM_CH)-1:0] ch_idx,
    output logic                      sample_stb,
    output logic                      frame_start,
    output logic                      overrun
);

    localparam int CHW  = $clog2(NUM_CH);
    localparam int MAXC = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0]  DEAD_LD   = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0]  SETTLE_LD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CHW-1:0] LAST_CH   = CHW'(NUM_CH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BREAK  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [CHW-1:0]    r_ptr;
    logic              r_sw_prev;
    logic              w_sw;
    logic              w_edge;
    logic [NUM_CH-1:0] w_onehot;

`ifdef SWITCH_SEQ_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    // Two-flop synchronizer for a switch clock that is asynchronous to clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= switch_clk;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sw = r_sync2;
`else
    assign w_sw = switch_clk;
`endif

    // Previous switch-clock sample, used for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sw_prev <= 1'b0;
        else     r_sw_prev <= w_sw;
    end

    assign w_edge   = w_sw & ~r_sw_prev;
    assign w_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << r_ptr;

    // Sequencer FSM. The channel close (MAKE) happens on the last BREAK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            sel         <= '0;
            ch_idx      <= '0;
            sample_stb  <= 1'b0;
            frame_start <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sample_stb  <= 1'b0;
            frame_start <= 1'b0;
            if (!enable) begin
                // Abort: open all switches and restart the frame at channel 0.
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_ptr   <= '0;
                sel     <= '0;
                ch_idx  <= '0;
                overrun <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_edge) begin
                            r_state <= S_BREAK;
                            r_cnt   <= DEAD_LD;
                            sel     <= '0;
                        end
                    end
                    S_BREAK: begin
                        if (w_edge) overrun <= 1'b1;
                        if (r_cnt == '0) begin
                            sel         <= w_onehot;
                            ch_idx      <= r_ptr;
                            frame_start <= (r_ptr == '0);
                            r_ptr       <= (r_ptr == LAST_CH) ? '0 : r_ptr + 1'b1;
                            r_cnt       <= SETTLE_LD;
                            r_state     <= S_SETTLE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (w_edge) overrun <= 1'b1;
                        if (r_cnt == '0) begin
                            sample_stb <= 1'b1;
                            r_state    <= S_HOLD;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_HOLD: begin
                        if (w_edge) begin
                            r_state <= S_BREAK;
                            r_cnt   <= DEAD_LD;
                            sel     <= '0;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_switch_sequencer.sv
// Scoreboard bench for switch_sequencer. Stimulus pushes the expected channel-close
// and strobe events, including their cycles. A negedge monitor pops and checks them.
module tb_switch_sequencer;

    localparam int NCH = 4;
    localparam int D   = 10;
    localparam int S   = 50;
    localparam int P   = 150;
`ifdef SWITCH_SEQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           switch_clk = 1'b0;
    logic           enable = 1'b0;
    logic [NCH-1:0] sel;
    logic [1:0]     ch_idx;
    logic           sample_stb;
    logic           frame_start;
    logic           overrun;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit stb;
        int ch;
        int cyc;
        bit fs;
    } exp_t;

    exp_t           q[$];
    exp_t           m_e;
    logic [NCH-1:0] m_prev_sel = '0;
    logic           m_close;

    switch_sequencer #(
        .NUM_CH        (NCH),
        .DEAD_CYCLES   (D),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .switch_clk  (switch_clk),
        .enable      (enable),
        .sel         (sel),
        .ch_idx      (ch_idx),
        .sample_stb  (sample_stb),
        .frame_start (frame_start),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected close at edge E+D and strobe at edge E+D+S, as seen at the following negedge.
    task automatic push_slot(input int ch, input int e, input bit with_stb);
        q.push_back('{stb: 1'b0, ch: ch, cyc: e + D, fs: (ch == 0)});
        if (with_stb) q.push_back('{stb: 1'b1, ch: ch, cyc: e + D + S, fs: 1'b0});
    endtask

    // Called at a negedge; raises switch_clk and returns the FSM edge cycle E.
    task automatic edge_now(output int e);
        e = cyc + LAT;
        switch_clk = 1'b1;
        repeat (3) @(negedge clk);
        switch_clk = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: check every close and strobe event against the head of the queue.
    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot", ($countones(sel) <= 1), 1);
            m_close = (sel != '0) && (m_prev_sel == '0);
            if (m_close) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL close_unexpected: got ch %0d expected none (cyc %0d)", ch_idx, cyc);
                end else begin
                    m_e = q.pop_front();
                    chk("close_kind", 0, m_e.stb);
                    chk("close_cyc", cyc, m_e.cyc);
                    chk("close_ch", ch_idx, m_e.ch);
                    chk("close_sel", sel, (1 << m_e.ch));
                    chk("close_fs", frame_start, m_e.fs);
                end
            end else if (frame_start) begin
                n_vec++; n_err++;
                $display("FAIL fs_stray: got 1 expected 0 (cyc %0d)", cyc);
            end
            if (sample_stb) begin
                if (q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL stb_unexpected: got 1 expected 0 (cyc %0d)", cyc);
                end else begin
                    m_e = q.pop_front();
                    chk("stb_kind", 1, m_e.stb);
                    chk("stb_cyc", cyc, m_e.cyc);
                end
            end
        end
        m_prev_sel = sel;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, e2;
        #1;
        chk("rst_sel", sel, 0);
        chk("rst_ch", ch_idx, 0);
        chk("rst_stb", sample_stb, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_ovr", overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b1;
        repeat (5) @(negedge clk);

        // Five edges: channels 0,1,2,3,0; dead window checked on the first.
        for (int i = 0; i < 5; i++) begin
            edge_now(e);
            push_slot(i % NCH, e, 1'b1);
            if (i == 0) begin
                wait_until(e);
                chk("dead_start_sel", sel, 0);
                wait_until(e + D - 1);
                chk("dead_end_sel", sel, 0);
                chk("dead_end_stb", sample_stb, 0);
            end
            wait_until(e + P);
        end

        // Edge during SETTLE: overrun set, sequence unchanged.
        edge_now(e);
        push_slot(1, e, 1'b1);
        wait_until(e + 30);
        edge_now(e2);
        wait_until(e2 + 1);
        chk("ovr_set", overrun, 1);
        wait_until(e + P);
        chk("ovr_sticky", overrun, 1);
        edge_now(e);
        push_slot(2, e, 1'b1);
        wait_until(e + P);

        // Enable drop mid-SETTLE: no strobe, idle, overrun cleared; restart at ch0.
        edge_now(e);
        push_slot(3, e, 1'b0);
        wait_until(e + 25);
        enable = 1'b0;
        @(negedge clk);
        chk("abort_sel", sel, 0);
        chk("abort_ovr", overrun, 0);
        wait_until(e + P);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        edge_now(e);
        push_slot(0, e, 1'b1);
        wait_until(e + P);

        // Asynchronous reset mid-SETTLE; the next edge lands on channel 0.
        edge_now(e);
        push_slot(1, e, 1'b0);
        wait_until(e + 40);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_ch", ch_idx, 0);
        chk("arst_stb", sample_stb, 0);
        chk("arst_fs", frame_start, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        edge_now(e);
        push_slot(0, e, 1'b1);
        wait_until(e + P);

        // Edge in the first HOLD cycle: strobe still fires and the next slot starts at once.
        edge_now(e);
        push_slot(1, e, 1'b1);
        wait_until(e + D + S + 1 - LAT);
        edge_now(e2);
        push_slot(2, e2, 1'b1);
        wait_until(e2);
        chk("hold_edge_sel", sel, 0);
        wait_until(e2 + P);
        chk("hold_edge_ovr", overrun, 0);

        chk("queue_drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
